// File: rtl/link_pkg.sv
// Shared sizing helpers for the credit-flow-controlled link.
// Imported by the receive buffer and the receiver top level.
package link_pkg;

    // Width of an occupancy counter that must hold values 0..depth inclusive.
    function automatic int unsigned CNT_W(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Smallest buffer depth that keeps the credit loop from limiting throughput.
    function automatic int unsigned LINK_MIN_DEPTH(input int unsigned fwd, input int unsigned ret);
        return fwd + ret + 2;
    endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// Receive buffer: unreset storage array, wrapping read/write pointers and an occupancy count.
// Full/empty come from the count alone, so the pointers never need an extra wrap bit.
module link_rx_fifo
    import link_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CW    = CNT_W(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CW-1:0]    o_count,
    output logic             o_pop,
    output logic             o_drop
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_d;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & i_rd_en;
    // A pop in the same cycle frees the slot the incoming beat needs.
    assign w_push  = i_wr_en & (~w_full | w_pop);

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_d;
        end
    end

    assign o_rd_valid = ~w_empty;
    assign o_rd_data  = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_pop      = w_pop;
    assign o_drop     = i_wr_en & w_full & ~w_pop;

endmodule

// File: rtl/link_credit_rx.sv
// Receiving end of a credit-flow-controlled link: buffers arriving beats, serves them in order,
// and returns one registered credit pulse per consumed beat.
module link_credit_rx
    import link_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic                      credit_out,
    output logic [CNT_W(DEPTH)-1:0]   count,
    output logic                      overflow
);

    logic w_pop;
    logic w_drop;
    logic r_credit;
    logic r_overflow;

    link_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (in_valid),
        .i_wr_data  (in_data),
        .i_rd_en    (out_ready),
        .o_rd_valid (out_valid),
        .o_rd_data  (out_data),
        .o_count    (count),
        .o_pop      (w_pop),
        .o_drop     (w_drop)
    );

    // Overflow is sticky: a dropped beat means the transmitter broke the credit contract.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit   <= w_pop;
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign credit_out = r_credit;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_link_credit_rx.sv
// Bench for link_credit_rx: directed scenarios plus a randomized closed credit loop,
// all checked against a queue-based model of the receive buffer.
module tb_link_credit_rx;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned FWD     = 3;
    localparam int unsigned RET     = 3;
    localparam int          N_BEATS = 10000;
    localparam int          MAX_CYC = 60000;

    logic                         clk;
    logic                         rst_n;
    logic                         in_valid;
    logic [WIDTH-1:0]             in_data;
    logic                         out_valid;
    logic [WIDTH-1:0]             out_data;
    logic                         out_ready;
    logic                         credit_out;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;

    link_credit_rx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .credit_out (credit_out),
        .count      (count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_credit;
    int               n_checks;
    int               n_errors;

    // Closed-loop transmitter and link chains.
    int               tx_credits;
    int               sent;
    int               rx_seq;
    bit               fwd_v [FWD];
    logic [WIDTH-1:0] fwd_d [FWD];
    bit               ret_p [RET];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_count"}, 32'(count), 32'(m_q.size()));
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
        check_eq({tag, "_credit"}, 32'(credit_out), 32'(m_credit));
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) check_eq({tag, "_data"}, 32'(out_data), 32'(m_q[0]));
    endtask

    // One clock cycle: drive inputs, check head, advance model by the edge, check results.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r,
                        output bit did_pop, output logic [WIDTH-1:0] head);
        int n;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        n    = m_q.size();
        head = out_data;
        check_eq("pre_valid", 32'(out_valid), 32'(n != 0));
        if (n != 0) check_eq("pre_data", 32'(out_data), 32'(m_q[0]));
        did_pop = (n != 0) && r;
        @(posedge clk);
        if (did_pop) void'(m_q.pop_front());
        if (v) begin
            if (n == DEPTH && !did_pop) m_ovf = 1'b1;
            else m_q.push_back(d);
        end
        m_credit = did_pop;
        #1;
        check_outputs("post");
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        m_q.delete();
        m_ovf    = 1'b0;
        m_credit = 1'b0;
        #1;
        check_outputs("rst_async");
        for (int i = 0; i < cycles; i++) begin
            in_valid  = i[0];
            in_data   = WIDTH'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            check_outputs("rst_hold");
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic loop_cycle(input bit allow_send);
        bit               p;
        bit               send;
        logic [WIDTH-1:0] d;
        int               in_flight;
        step(fwd_v[FWD-1], fwd_d[FWD-1], ($urandom_range(0, 9) < 7), p, d);
        if (p) begin
            check_eq("order", 32'(d), 32'(rx_seq[WIDTH-1:0]));
            rx_seq++;
        end
        tx_credits += int'(ret_p[RET-1]);
        for (int i = RET - 1; i > 0; i--) ret_p[i] = ret_p[i-1];
        ret_p[0] = credit_out;
        send = allow_send && (sent < N_BEATS) && (tx_credits > 0) && ($urandom_range(0, 9) < 9);
        for (int i = FWD - 1; i > 0; i--) begin
            fwd_v[i] = fwd_v[i-1];
            fwd_d[i] = fwd_d[i-1];
        end
        fwd_v[0] = send;
        fwd_d[0] = sent[WIDTH-1:0];
        if (send) begin
            tx_credits--;
            sent++;
        end
        // Every credit is at the transmitter, on a chain, or held by a buffered beat.
        in_flight = 0;
        for (int i = 0; i < FWD; i++) in_flight += int'(fwd_v[i]);
        for (int i = 0; i < RET; i++) in_flight += int'(ret_p[i]);
        check_eq("credit_sum", 32'(tx_credits + in_flight + int'(count)), 32'(DEPTH));
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "bench hung");
    end

    initial begin : main
        bit               p;
        logic [WIDTH-1:0] d;
        int               creds;
        int               cyc;

        n_checks  = 0;
        n_errors  = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        do_reset(4);

        // Single beat through an empty buffer.
        step(1'b1, 8'hA5, 1'b1, p, d);
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_data", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, p, d);
        check_eq("single_credit", 32'(credit_out), 32'd1);
        check_eq("single_count", 32'(count), 32'd0);
        step(1'b0, 8'h00, 1'b1, p, d);

        // Fill, overflow, drain.
        for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b0, p, d);
        check_eq("fill_count", 32'(count), 32'd8);
        check_eq("fill_ovf", 32'(overflow), 32'd0);
        step(1'b1, 8'h09, 1'b0, p, d);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        check_eq("ovf_count", 32'(count), 32'd8);
        creds = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1, p, d);
            check_eq("drain_data", 32'(d), 32'(i));
            creds += int'(credit_out);
        end
        step(1'b0, 8'h00, 1'b1, p, d);
        creds += int'(credit_out);
        check_eq("drain_credits", 32'(creds), 32'd8);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop together at full.
        do_reset(1);
        for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b0, p, d);
        step(1'b1, 8'h10, 1'b1, p, d);
        check_eq("pp_ovf", 32'(overflow), 32'd0);
        check_eq("pp_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, p, d);
        check_eq("pp_last", 32'(d), 32'h10);

        // Reset mid-stream.
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0, p, d);
        check_eq("mid_count", 32'(count), 32'd5);
        do_reset(1);
        creds = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, p, d);
            creds += int'(credit_out);
        end
        check_eq("mid_no_credit", 32'(creds), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'h21 + i), 1'b1, p, d);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, p, d);

        // Closed credit loop.
        do_reset(1);
        tx_credits = DEPTH;
        sent       = 0;
        rx_seq     = 0;
        for (int i = 0; i < FWD; i++) begin
            fwd_v[i] = 1'b0;
            fwd_d[i] = '0;
        end
        for (int i = 0; i < RET; i++) ret_p[i] = 1'b0;
        cyc = 0;
        while (rx_seq < N_BEATS && cyc < MAX_CYC) begin
            loop_cycle(1'b1);
            cyc++;
        end
        check_eq("loop_done", 32'(rx_seq), 32'(N_BEATS));
        for (int i = 0; i < 12; i++) loop_cycle(1'b0);
        check_eq("loop_credits", 32'(tx_credits), 32'(DEPTH));
        check_eq("loop_ovf", 32'(overflow), 32'd0);
        check_eq("loop_empty", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
